// File: rtl/max31855_poll_ctrl.sv
// -----------------------------------------------------------------------------
// max31855_poll_ctrl
//
// Periodically polls a MAX31855 thermocouple converter through an external SPI
// reader and forwards every captured 32-bit frame to a UART transmitter as a
// 6-byte packet: 0xA5, frame[31:24], frame[23:16], frame[15:8], frame[7:0],
// XOR of the four frame bytes.
//
// Parameters
//   SAMPLE_PERIOD : poll interval in clk cycles (min 16)
//   SPI_TIMEOUT   : max clk cycles allowed from spi_start to spi_done
//
// Ports
//   clk         in   sole clock, rising edge
//   reset       in   synchronous, active-low reset
//   sample_en   in   enables periodic polling
//   spi_start   out  one-cycle start pulse to the SPI reader
//   spi_busy    in   SPI reader transaction in progress
//   spi_done    in   one-cycle pulse, spi_frame valid
//   spi_frame   in   raw MAX31855 frame (bit 31 first on the wire)
//   tx_data     out  byte to UART transmitter
//   tx_valid    out  tx_data valid
//   tx_ready    in   UART transmitter accepts byte
//   fault       out  bit 16 of the last captured frame
//   fault_code  out  bits [2:0] (SCV,SCG,OC) of the last captured frame
//   overrun     out  sticky: a poll tick arrived while busy and was dropped
//   timeout_err out  sticky: the SPI reader did not answer within SPI_TIMEOUT
// -----------------------------------------------------------------------------
module max31855_poll_ctrl #(
  parameter int SAMPLE_PERIOD = 10000000,
  parameter int SPI_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [31:0] spi_frame,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int CNT_W  = $clog2(SAMPLE_PERIOD);
  localparam int WAIT_W = $clog2(SPI_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SPI_TIMEOUT - 1);
  localparam logic [2:0]        LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_SPI = 2'd2,
    SEND     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        frame_q, frame_d;
  logic               fault_q, fault_d;
  logic [2:0]         fault_code_q, fault_code_d;
  logic               overrun_q, overrun_d;
  logic               timeout_err_q, timeout_err_d;

  logic               tick;
  logic               timeout_hit;
  logic               byte_xfer;
  logic [7:0]         frame_byte [4];
  logic [7:0]         checksum;
  logic [7:0]         send_byte;

  // Frame bytes in wire order: frame_byte[0] is the most significant byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_frame_bytes
    assign frame_byte[gi] = frame_q[31 - 8*gi -: 8];
  end

  assign checksum    = frame_byte[0] ^ frame_byte[1] ^ frame_byte[2] ^ frame_byte[3];
  assign tick        = (tick_cnt_q == CNT_MAX);
  // Counter reaches SPI_TIMEOUT-1 on the SPI_TIMEOUT-th cycle in WAIT_SPI.
  assign timeout_hit = (state_q == WAIT_SPI) && !spi_done && (wait_cnt_q == WAIT_MAX);
  assign byte_xfer   = (state_q == SEND) && tx_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tick) state_d = START;
      START:    if (!spi_busy) state_d = WAIT_SPI;
      WAIT_SPI: begin
        if (spi_done)         state_d = SEND;
        else if (timeout_hit) state_d = IDLE;
      end
      SEND:     if (byte_xfer && (byte_idx_q == LAST_BYTE)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    case (byte_idx_q)
      3'd0:    send_byte = 8'hA5;
      3'd1:    send_byte = frame_byte[0];
      3'd2:    send_byte = frame_byte[1];
      3'd3:    send_byte = frame_byte[2];
      3'd4:    send_byte = frame_byte[3];
      default: send_byte = checksum;
    endcase
  end

  always_comb begin
    spi_start = (state_q == START) && !spi_busy;
    tx_valid  = (state_q == SEND);
    tx_data   = (state_q == SEND) ? send_byte : 8'h00;
  end

  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    byte_idx_d    = byte_idx_q;
    frame_d       = frame_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;

    if (!sample_en)  tick_cnt_d = '0;
    else if (tick)   tick_cnt_d = '0;
    else             tick_cnt_d = tick_cnt_q + 1'b1;

    // Counts from 0 on the first cycle spent in WAIT_SPI.
    if (state_q == WAIT_SPI) wait_cnt_d = wait_cnt_q + 1'b1;
    else                     wait_cnt_d = '0;

    if (state_q != SEND) byte_idx_d = '0;
    else if (tx_ready)   byte_idx_d = byte_idx_q + 1'b1;

    // spi_done is only meaningful while a transaction is being awaited.
    if ((state_q == WAIT_SPI) && spi_done) begin
      frame_d      = spi_frame;
      fault_d      = spi_frame[16];
      fault_code_d = spi_frame[2:0];
    end

    // A tick that cannot start a poll is dropped, not queued.
    if (tick && (state_q != IDLE)) overrun_d = 1'b1;
    if (timeout_hit)               timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      byte_idx_q    <= '0;
      frame_q       <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= 3'b000;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      byte_idx_q    <= byte_idx_d;
      frame_q       <= frame_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: doc/max31855_poll_ctrl.md
MAX31855_POLL_CTRL -- requirements
Module: max31855_poll_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 10000000, poll interval in clk cycles (min 16).
REQ-002 SHALL have parameter SPI_TIMEOUT, default 4096, max clk cycles from spi_start to spi_done.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sample_en  input  1  enables periodic polling.
REQ-006 SHALL have port spi_start  output  1  one-cycle start pulse to the MAX31855 SPI reader.
REQ-007 SHALL have port spi_busy  input  1  SPI reader transaction in progress.
REQ-008 SHALL have port spi_done  input  1  one-cycle pulse, spi_frame valid.
REQ-009 SHALL have port spi_frame  input  32  raw MAX31855 frame, bit 31 first on the wire.
REQ-010 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-011 SHALL have port tx_valid  output  1  tx_data valid.
REQ-012 SHALL have port tx_ready  input  1  UART transmitter accepts byte.
REQ-013 SHALL have port fault  output  1  frame bit 16 of last captured frame.
REQ-014 SHALL have port fault_code  output  3  frame bits [2:0] (SCV,SCG,OC) of last captured frame.
REQ-015 SHALL have port overrun  output  1  sticky: a poll tick was missed.
REQ-016 SHALL have port timeout_err  output  1  sticky: SPI_TIMEOUT expired.

Function
REQ-017 Tick counter SHALL count 0..SAMPLE_PERIOD-1 and wrap while sample_en=1, held at 0 while sample_en=0; tick = count==SAMPLE_PERIOD-1.
REQ-018 FSM states SHALL be IDLE, START, WAIT_SPI, SEND.
REQ-019 IDLE -> START on tick; START SHALL assert spi_start for exactly one cycle when spi_busy=0 and remain in START (spi_start low) while spi_busy=1.
REQ-020 START -> WAIT_SPI in the cycle after the spi_start pulse; WAIT_SPI SHALL count cycles from 0.
REQ-021 On spi_done in WAIT_SPI (cycle N): latch spi_frame, update fault/fault_code, enter SEND; tx_valid=1, tx_data=0xA5 at N+1.
REQ-022 WAIT_SPI count reaching SPI_TIMEOUT without spi_done SHALL set timeout_err, return to IDLE, send nothing, leave fault/fault_code unchanged.
REQ-023 SEND SHALL emit 6 bytes in order: 0xA5, frame[31:24], frame[23:16], frame[15:8], frame[7:0], XOR of the four frame bytes.
REQ-024 A byte SHALL transfer on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL remain stable and tx_valid high until transfer; next byte presented the following cycle.
REQ-025 After the 6th byte transfers, FSM SHALL return to IDLE with tx_valid=0 that cycle after.
REQ-026 Tick while state != IDLE SHALL set overrun and be discarded (no queuing).
REQ-027 sample_en falling mid-transaction SHALL not abort; current frame completes through SEND.
REQ-028 spi_done outside WAIT_SPI SHALL be ignored.
REQ-029 Tick and timeout in the same cycle: timeout_err and overrun both set, FSM to IDLE.

Reset
REQ-030 reset=0 at a clk edge SHALL force IDLE, tick counter 0, spi_start=0, tx_valid=0, tx_data=0, fault=0, fault_code=0, overrun=0, timeout_err=0, regardless of state (including mid-SEND).
REQ-031 overrun and timeout_err SHALL clear only by reset.

Verification
REQ-032 SAMPLE_PERIOD=16, sample_en=1 from reset release -> spi_start pulse 1 cycle after 16th cycle, repeating every 16 cycles.
REQ-033 spi_frame=0x019C1A70 with spi_done, tx_ready=1 -> bytes A5 01 9C 1A 70 F7 on consecutive cycles, fault=0, fault_code=000.
REQ-034 spi_frame=0x00010004 -> fault=1, fault_code=100, bytes A5 00 01 00 04 05.
REQ-035 tx_ready toggling 0/1 each cycle -> each byte held stable until accepted, order unchanged, 12 cycles in SEND.
REQ-036 SPI_TIMEOUT=32, spi_done never asserted -> timeout_err=1 after 32 cycles in WAIT_SPI, no tx_valid, next tick restarts poll.
REQ-037 reset=0 during 3rd byte of SEND -> all outputs 0 next cycle; after release, first spi_start after SAMPLE_PERIOD cycles.
